// File: rtl/logic_gate_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_gate_pkg;

  localparam int OP_W    = 3;
  localparam int NUM_OPS = 8;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_XNOR  = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_NOT_A = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_op.sv
// Combinational WIDTH-bit bitwise function selected by opcode.
module logic_gate_op
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y
);

  always_comb begin
    Y = A;
    case (op)
      OP_AND:    Y = A & B;
      OP_OR:     Y = A | B;
      OP_XOR:    Y = A ^ B;
      OP_XNOR:   Y = ~(A ^ B);
      OP_NAND:   Y = ~(A & B);
      OP_NOR:    Y = ~(A | B);
      OP_NOT_A:  Y = ~A;
      OP_PASS_A: Y = A;
      default:   Y = A;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready bitwise logic unit with reduction flags.
// Optional transaction counter on txn_count built when LOGIC_STATS_EN is defined.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             all_ones,
  output logic             any_one
`ifdef LOGIC_STATS_EN
  ,
  output logic [CNT_W-1:0] txn_count
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
    $error("logic_gate_pipe: WIDTH and CNT_W must be >= 1");
  end

  logic             s1_valid, s2_valid;
  logic             s1_take, s2_take;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH-1:0] y_next;

  // Ready ripples back combinationally so a full pipe still streams 1/cycle.
  assign s2_take  = !s2_valid || out_ready;
  assign s1_take  = !s1_valid || s2_take;
  assign in_ready = s1_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_take) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op_e'(op);
        s1_a  <= A;
        s1_b  <= B;
      end
    end
  end

  logic_gate_op #(.WIDTH(WIDTH)) u_op (
    .op (s1_op),
    .A  (s1_a),
    .B  (s1_b),
    .Y  (y_next)
  );

  // Data regs only load on a real transfer so a bubble leaves the last result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      Y        <= '0;
      all_ones <= 1'b0;
      any_one  <= 1'b0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Y        <= y_next;
        all_ones <= &y_next;
        any_one  <= |y_next;
      end
    end
  end

  assign out_valid = s2_valid;

`ifdef LOGIC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        txn_count <= '0;
    else if (out_valid && out_ready) txn_count <= txn_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed + random bench for logic_gate_pipe with an in-order scoreboard.
module tb_logic_gate_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Y;
  logic         all_ones;
  logic         any_one;
`ifdef LOGIC_STATS_EN
  logic [CW-1:0] txn_count;
`endif

  logic_gate_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .all_ones  (all_ones),
    .any_one   (any_one)
`ifdef LOGIC_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  int n_pop = 0;
  int base_push, base_pop, guard, pre;
  logic [W+1:0] q[$];
  logic [W-1:0] sweep_exp [8];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {all_ones, any_one, Y}
  function automatic logic [W+1:0] model(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] y;
    case (o)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = ~(a ^ b);
      3'd4: y = ~(a & b);
      3'd5: y = ~(a | b);
      3'd6: y = ~a;
      default: y = a;
    endcase
    return {&y, |y, y};
  endfunction

  task automatic sb_eval();
    logic [W+1:0] e;
    if (rst) return;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_spurious", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_result", {22'd0, all_ones, any_one, Y}, {22'd0, e});
        n_pop++;
      end
    end
    if (in_valid && in_ready) begin
      chk("op_known", {31'd0, $isunknown(op)}, 32'd0);
      q.push_back(model(op, A, B));
      n_push++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    sb_eval();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    next();
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_flags_y", {22'd0, all_ones, any_one, Y}, 32'd0);
`ifdef LOGIC_STATS_EN
    chk("reset_txn", {28'd0, txn_count}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    sample();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    next();

    // Op sweep with latency check
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      op = (i < 8) ? 3'(i) : 3'd0;
      A = 8'hF0; B = 8'hCC;
      sample();
      chk("sweep_valid", {31'd0, out_valid}, {31'd0, (i >= 2)});
      if (i >= 2) chk("sweep_y", {24'd0, Y}, {24'd0, sweep_exp[i-2]});
      next();
    end

    // XNOR equality flags
    in_valid = 1'b1; op = 3'd3; A = 8'hA5; B = 8'hA5;
    cycle();
    B = 8'h5A;
    cycle();
    in_valid = 1'b0;
    sample();
    chk("xnor_eq", {22'd0, all_ones, any_one, Y}, {22'd0, 2'b11, 8'hFF});
    next();
    sample();
    chk("xnor_ne", {22'd0, all_ones, any_one, Y}, {22'd0, 2'b00, 8'h00});
    next();

    // Backpressure: 2 accepted, then stall
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; B = 8'h00;
    A = 8'h01;
    cycle();
    A = 8'h02;
    cycle();
    A = 8'h03;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {23'd0, out_valid, Y}, {23'd0, 1'b1, 8'h01});
      next();
    end
    out_ready = 1'b1;
    sample();
    chk("bp_out1", {23'd0, out_valid, Y}, {23'd0, 1'b1, 8'h01});
    chk("bp_reopen", {31'd0, in_ready}, 32'd1);
    next();
    in_valid = 1'b0;
    sample();
    chk("bp_out2", {23'd0, out_valid, Y}, {23'd0, 1'b1, 8'h02});
    next();
    sample();
    chk("bp_out3", {23'd0, out_valid, Y}, {23'd0, 1'b1, 8'h03});
    next();
    sample();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    next();

    // Reset mid-stream with both stages full
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd7; A = 8'h11;
    cycle();
    A = 8'h22;
    cycle();
    in_valid = 1'b0;
    sample();
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
      next();
    end

    // Random valid/ready traffic
    base_push = n_push; base_pop = n_pop; guard = 0;
    while (n_push - base_push < 1000 && guard < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom);
      A = 8'($urandom);
      B = 8'($urandom);
      cycle();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1; guard = 0;
    while (q.size() != 0 && guard < 100) begin
      cycle();
      guard++;
    end
    chk("rand_sent", 32'(n_push - base_push), 32'd1000);
    chk("rand_recv", 32'(n_pop - base_pop), 32'd1000);
    chk("rand_drained", 32'(q.size()), 32'd0);

`ifdef LOGIC_STATS_EN
    // Counter wrap and stall behaviour
    sample();
    pulse_reset();
    chk("txn_zero", {28'd0, txn_count}, 32'd0);
    base_pop = n_pop;
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd1; A = 8'h0F; B = 8'h30;
    for (int i = 0; i < 5; i++) cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pre = n_pop;
      sample();
      chk("txn_stall", {28'd0, txn_count}, 32'(4'(pre - base_pop)));
      next();
    end
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    in_valid = 1'b0; guard = 0;
    while (q.size() != 0 && guard < 100) begin
      cycle();
      guard++;
    end
    chk("txn_handshakes", 32'(n_pop - base_pop), 32'd17);
    chk("txn_wrap", {28'd0, txn_count}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
